// File: rtl/load_store_unit_if.sv
// Core-side access and data-memory bus signals of the load/store unit.
// The master modport is the load/store unit itself (it masters the memory bus
// and answers the core); the slave modport is the core plus memory environment.
interface load_store_unit_if;
  // core request
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  // core response
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_cause;
  // data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req, we, funct3, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
    output busy, done, rdata, err, err_cause,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req, we, funct3, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
    input  busy, done, rdata, err, err_cause,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time from the core onto a word-addressed
// data-memory bus, with lane steering, strobes, load extension and error
// reporting (misaligned, illegal funct3, bus timeout). All outputs registered.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  load_store_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       cause_nx;

  // access attributes kept for the load extract
  logic       acc_we;
  logic [2:0] acc_f3;
  logic [1:0] acc_off;

  logic        illegal_c, misaligned_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] lane_c, ext_c;

  // Decode of the incoming request: legality, alignment, strobes, replicated data
  always_comb begin
    illegal_c    = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                   (bus.funct3 == 3'b111) || (bus.we && bus.funct3[2]);
    misaligned_c = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                   ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    be_c         = 4'b1111;
    wdata_c      = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << bus.addr[1:0];
        wdata_c = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {bus.addr[1], 1'b0};
        wdata_c = {2{bus.wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = bus.wdata;
      end
    endcase
  end

  // Lane extract and sign/zero extension of the returned read word
  always_comb begin
    lane_c = bus.mem_rdata >> {acc_off, 3'b000};
    ext_c  = lane_c;
    case (acc_f3)
      3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b100:  ext_c = {24'd0, lane_c[7:0]};
      3'b101:  ext_c = {16'd0, lane_c[15:0]};
      default: ext_c = lane_c;
    endcase
  end

  // Next-state logic with the shared REQ/WAIT timeout counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cause_nx = 2'b00;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (illegal_c) begin
            state_nx = ERR;
            cause_nx = CAUSE_ILLEGAL;
          end else if (misaligned_c) begin
            state_nx = ERR;
            cause_nx = CAUSE_MISALIGN;
          end else begin
            state_nx = REQ;
            cnt_nx   = '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          state_nx = acc_we ? DONE : WAIT;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx = ERR;
          cause_nx = CAUSE_TIMEOUT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nx = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx = ERR;
          cause_nx = CAUSE_TIMEOUT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered outputs decoded from the next state, plus access capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_cause <= 2'b00;
      bus.rdata     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      acc_we        <= 1'b0;
      acc_f3        <= 3'b000;
      acc_off       <= 2'b00;
    end else begin
      bus.busy    <= (state_nx != IDLE);
      bus.done    <= (state_nx == DONE);
      bus.err     <= (state_nx == ERR);
      bus.mem_req <= (state_nx == REQ);
      if (state_nx == ERR) begin
        bus.err_cause <= cause_nx;
      end
      if ((state == WAIT) && (state_nx == DONE)) begin
        bus.rdata <= ext_c;
      end
      if ((state == IDLE) && bus.req) begin
        acc_we  <= bus.we;
        acc_f3  <= bus.funct3;
        acc_off <= bus.addr[1:0];
      end
      if ((state == IDLE) && (state_nx == REQ)) begin
        bus.mem_we    <= bus.we;
        bus.mem_addr  <= {bus.addr[31:2], 2'b00};
        bus.mem_be    <= be_c;
        bus.mem_wdata <= wdata_c;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses against a behavioural access-level model (byte-lane arithmetic and
// a per-access event schedule).
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // model state that persists between accesses
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_cause = 2'b00;

  // single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected load result from the word, byte offset and funct3
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] word);
    logic [31:0] lane;
    int v;
    lane = word >> (8 * off);
    case (f3)
      3'b000: begin v = int'(lane & 32'hFF);   if (v >= 128)   v -= 256;   end
      3'b001: begin v = int'(lane & 32'hFFFF); if (v >= 32768) v -= 65536; end
      3'b100: v = int'(lane & 32'hFF);
      3'b101: v = int'(lane & 32'hFFFF);
      default: v = int'(lane);
    endcase
    return 32'(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},   32'(bus.busy), 32'd0);
    check({tag, ".done"},   32'(bus.done), 32'd0);
    check({tag, ".err"},    32'(bus.err), 32'd0);
    check({tag, ".cause"},  32'(bus.err_cause), 32'd0);
    check({tag, ".rdata"},  bus.rdata, 32'd0);
    check({tag, ".mreq"},   32'(bus.mem_req), 32'd0);
    check({tag, ".mwe"},    32'(bus.mem_we), 32'd0);
    check({tag, ".maddr"},  bus.mem_addr, 32'd0);
    check({tag, ".mbe"},    32'(bus.mem_be), 32'd0);
    check({tag, ".mwdata"}, bus.mem_wdata, 32'd0);
  endtask

  // One complete access: rd = cycles mem_ready is withheld in REQ,
  // rv = cycles mem_rvalid is withheld in WAIT, word = read data returned.
  task automatic do_access(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int rd, input int rv, input logic [31:0] word);
    bit illegal, misal, ends_ok;
    int n, first, off;
    int c_ready, c_rvalid, c_wait, c_req_last, c_end;
    logic [3:0]  be;
    logic [31:0] wd, exp_r;
    logic [1:0]  exp_cause;

    illegal = (f3 == 3'b011) || (f3 >= 3'b110) || (we && (f3 >= 3'b100));
    n       = 1 << f3[1:0];
    off     = int'(addr % 4);
    misal   = !illegal && ((off % n) != 0);
    first   = off - (off % n);
    for (int i = 0; i < 4; i++) begin
      be[i]          = (i >= first) && (i < first + n);
      wd[8*i +: 8]   = wdata[8*(i % n) +: 8];
    end

    check({name, ".idle"}, 32'(bus.busy), 32'd0);
    bus.req    = 1'b1;
    bus.we     = we;
    bus.funct3 = f3;
    bus.addr   = addr;
    bus.wdata  = wdata;
    tick();
    // scramble the request fields to prove they were latched
    bus.req    = 1'b0;
    bus.we     = 1'($urandom);
    bus.funct3 = 3'($urandom);
    bus.addr   = $urandom;
    bus.wdata  = $urandom;

    if (illegal || misal) begin
      exp_cause = illegal ? 2'b10 : 2'b01;
      check({name, ".err"},   32'(bus.err), 32'd1);
      check({name, ".cause"}, 32'(bus.err_cause), 32'(exp_cause));
      check({name, ".mreq"},  32'(bus.mem_req), 32'd0);
      check({name, ".done"},  32'(bus.done), 32'd0);
      last_cause = exp_cause;
      tick();
    end else begin
      // event schedule, cycle 0 being the accept cycle
      c_ready  = -1;
      c_rvalid = -1;
      c_wait   = -1;
      exp_r    = last_rdata;
      if (rd >= int'(TIMEOUT)) begin
        c_req_last = TIMEOUT;
        c_end      = 1 + TIMEOUT;
        ends_ok    = 1'b0;
      end else begin
        c_ready    = 1 + rd;
        c_req_last = c_ready;
        if (we) begin
          c_end   = c_ready + 1;
          ends_ok = 1'b1;
        end else begin
          c_wait = c_ready + 1;
          if (rv >= int'(TIMEOUT)) begin
            c_end   = c_wait + TIMEOUT;
            ends_ok = 1'b0;
          end else begin
            c_rvalid = c_wait + rv;
            c_end    = c_rvalid + 1;
            ends_ok  = 1'b1;
            exp_r    = ref_load(f3, off, word);
          end
        end
      end

      for (int c = 1; c <= c_end; c++) begin
        if (c <= c_req_last) begin
          check({name, ".mreq"},   32'(bus.mem_req), 32'd1);
          check({name, ".maddr"},  bus.mem_addr, {addr[31:2], 2'b00});
          check({name, ".mbe"},    32'(bus.mem_be), 32'(be));
          check({name, ".mwdata"}, bus.mem_wdata, we ? wd : bus.mem_wdata);
          check({name, ".mwe"},    32'(bus.mem_we), 32'(we));
        end else begin
          check({name, ".mreq_lo"}, 32'(bus.mem_req), 32'd0);
        end
        check({name, ".done"}, 32'(bus.done), 32'((c == c_end) && ends_ok));
        check({name, ".err"},  32'(bus.err),  32'((c == c_end) && !ends_ok));
        if (c == c_end) begin
          if (ends_ok) begin
            last_rdata = exp_r;
          end else begin
            last_cause = 2'b11;
          end
          check({name, ".rdata"}, bus.rdata, last_rdata);
          check({name, ".cause"}, 32'(bus.err_cause), 32'(last_cause));
        end
        // bus responses; rvalid outside WAIT carries junk and must be ignored
        bus.mem_ready  = (c == c_ready);
        if (c == c_rvalid) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = word;
        end else begin
          bus.mem_rvalid = (c <= c_req_last || c == c_end) ? 1'($urandom) : 1'b0;
          bus.mem_rdata  = $urandom;
        end
        // core requests while busy must be ignored
        bus.req    = 1'($urandom);
        bus.we     = 1'($urandom);
        bus.funct3 = 3'($urandom);
        bus.addr   = $urandom;
        tick();
      end
    end

    bus.req        = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    check({name, ".busy_end"},  32'(bus.busy), 32'd0);
    check({name, ".done_end"},  32'(bus.done), 32'd0);
    check({name, ".err_end"},   32'(bus.err), 32'd0);
    check({name, ".rdata_hold"}, bus.rdata, last_rdata);
    check({name, ".cause_hold"}, 32'(bus.err_cause), 32'(last_cause));
  endtask

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          r_rd, r_rv;

    rst            = 1'b1;
    bus.req        = 1'b0;
    bus.we         = 1'b0;
    bus.funct3     = 3'b000;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // directed scenarios
    do_access("sb103",   1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
    do_access("lb102",   1'b0, 3'b000, 32'h0000_0102, 32'h0, 0, 0, 32'h12F0_3456);
    check("lb102.spec", last_rdata, 32'hFFFF_FFF0);
    do_access("lbu102",  1'b0, 3'b100, 32'h0000_0102, 32'h0, 0, 1, 32'h12F0_3456);
    check("lbu102.spec", last_rdata, 32'h0000_00F0);
    do_access("lhu102",  1'b0, 3'b101, 32'h0000_0102, 32'h0, 1, 0, 32'h12F0_3456);
    check("lhu102.spec", last_rdata, 32'h0000_12F0);
    do_access("lw101",   1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    check("lw101.spec", 32'(last_cause), 32'd1);
    do_access("f3_011",  1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 32'h0);
    check("f3_011.spec", 32'(last_cause), 32'd2);
    do_access("sbu",     1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 0, 32'h0);
    do_access("sw_wait", 1'b1, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 3, 0, 32'h0);
    do_access("sh_hi",   1'b1, 3'b001, 32'h0000_0306, 32'h0000_BEEF, 0, 0, 32'h0);
    do_access("lw_tmo",  1'b0, 3'b010, 32'h0000_0400, 32'h0, 0, TIMEOUT, 32'h0);
    do_access("sw_tmo",  1'b1, 3'b010, 32'h0000_0404, 32'h1, TIMEOUT, 0, 32'h0);
    do_access("lh_neg",  1'b0, 3'b001, 32'h0000_0500, 32'h0, 0, TIMEOUT - 1, 32'h0000_8001);

    // reset while in WAIT abandons the access silently
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'h0000_0600;
    tick();
    bus.req       = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    rst           = 1'b1;
    tick();
    check_reset_outputs("rst_wait");
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    last_rdata     = '0;
    last_cause     = 2'b00;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rst_wait.no_done", 32'(bus.done), 32'd0);
    check("rst_wait.no_err",  32'(bus.err), 32'd0);
    check("rst_wait.rdata",   bus.rdata, 32'd0);
    do_access("lw_after_rst", 1'b0, 3'b010, 32'h0000_0608, 32'h0, 0, 0, 32'h1234_5678);

    // randomized accesses
    for (int t = 0; t < 150; t++) begin
      r_we   = 1'($urandom);
      r_f3   = 3'($urandom);
      r_addr = $urandom;
      r_rd   = ($urandom_range(0, 11) == 0) ? int'(TIMEOUT) + $urandom_range(0, 2)
                                            : $urandom_range(0, 3);
      r_rv   = ($urandom_range(0, 11) == 0) ? int'(TIMEOUT) + $urandom_range(0, 2)
                                            : $urandom_range(0, 3);
      do_access("rand", r_we, r_f3, r_addr, $urandom, r_rd, r_rv, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
